// File: rtl/lola_p.sv
// lola_p: iterative 257-bit keyless permutation (chi, pi, iota), one round per clock.
// Optional LOLAP_OUT_MASK_EN: state_o is forced to zero whenever done is low.
module lola_p #(
    parameter int NUM_ROUNDS = 1,
    parameter int PI_MUL     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [256:0] state_i,
    output logic         busy,
    output logic         done,
    output logic [256:0] state_o
);

    localparam int N     = 257;
    localparam int CNT_W = $clog2(NUM_ROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - 1);

    typedef enum logic {IDLE, RUN} st_t;

    st_t              st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adv, fin;
    logic             done_q;
    logic [N-1:0]     state_p1, res_p1;
    logic [N-1:0]     rnd_in, chi_b, pi_c, rnd_out;
    logic [7:0]       rc;

    // Round datapath: the first round of a run reads state_i, later rounds the register.
    assign rnd_in = (st_q == RUN) ? state_p1 : state_i;
    assign rc     = 8'(cnt_q) + 8'd1;

    for (genvar i = 0; i < N; i++) begin : g_round
        localparam int I1 = (i + 1) % N;
        localparam int I2 = (i + 2) % N;
        localparam int PI = (PI_MUL * i) % N;
        assign chi_b[i]  = rnd_in[i] ^ (~rnd_in[I1] & rnd_in[I2]);
        assign pi_c[PI]  = chi_b[i];
    end

    assign rnd_out = {pi_c[N-1:8], pi_c[7:0] ^ rc};

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        adv   = 1'b0;
        fin   = 1'b0;
        case (st_q)
            IDLE: begin
                if (start) begin
                    adv = 1'b1;
                    if (NUM_ROUNDS == 1) begin
                        fin = 1'b1;
                    end else begin
                        st_d  = RUN;
                        cnt_d = CNT_W'(1);
                    end
                end
            end
            RUN: begin
                adv = 1'b1;
                if (cnt_q == LAST) begin
                    fin   = 1'b1;
                    st_d  = IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                st_d  = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // Stage p1: round register, result register and control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            state_p1 <= '0;
            res_p1   <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            done_q <= fin;
            if (adv) begin
                state_p1 <= rnd_out;
            end
            if (fin) begin
                res_p1 <= rnd_out;
            end
        end
    end

    assign busy = (st_q == RUN);
    assign done = done_q;

`ifdef LOLAP_OUT_MASK_EN
    assign state_o = done_q ? res_p1 : '0;
`else
    assign state_o = res_p1;
`endif

endmodule

// File: tb/tb_lola_p.sv
// Scoreboard bench for lola_p: a 1-round instance and a 4-round instance checked
// against a plain-arithmetic model of the round equations.
module tb_lola_p;

    localparam int PI_MUL = 3;

    typedef struct {
        logic [256:0] val;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_a_n, rst_b_n;
    logic         start_a, start_b;
    logic [256:0] state_i_a, state_i_b;
    logic         busy_a, busy_b, done_a, done_b;
    logic [256:0] state_o_a, state_o_b;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [256:0] last_a = '0;
    logic [256:0] last_b = '0;

    lola_p #(.NUM_ROUNDS(1), .PI_MUL(PI_MUL)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .start(start_a), .state_i(state_i_a),
        .busy(busy_a), .done(done_a), .state_o(state_o_a)
    );

    lola_p #(.NUM_ROUNDS(4), .PI_MUL(PI_MUL)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .start(start_b), .state_i(state_i_b),
        .busy(busy_b), .done(done_b), .state_o(state_o_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [256:0] model(input logic [256:0] a_in, input int rounds);
        logic [256:0] a, b, c;
        a = a_in;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 257; i++)
                b[i] = a[i] ^ (~a[(i + 1) % 257] & a[(i + 2) % 257]);
            for (int i = 0; i < 257; i++)
                c[(PI_MUL * i) % 257] = b[i];
            c[7:0] = c[7:0] ^ 8'(r + 1);
            a = c;
        end
        return a;
    endfunction

    function automatic logic [256:0] rand257();
        logic [287:0] t;
        for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom;
        return t[256:0];
    endfunction

    function automatic logic [256:0] idle_view(input logic [256:0] v);
`ifdef LOLAP_OUT_MASK_EN
        return '0;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard on every done, otherwise check the held output.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_a_n) begin
            last_a = '0;
        end else begin
            chk("a_busy", 257'(busy_a), 257'(0));
            if (done_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_done", 257'(1), 257'(0));
                end else begin
                    e = q_a.pop_front();
                    chk("a_done_cycle", 257'(cyc), 257'(e.cyc));
                    chk("a_state_o", state_o_a, e.val);
                    last_a = e.val;
                end
            end else begin
                chk("a_hold", state_o_a, idle_view(last_a));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_b_n) begin
            last_b = '0;
        end else if (done_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_done", 257'(1), 257'(0));
            end else begin
                e = q_b.pop_front();
                chk("b_done_cycle", 257'(cyc), 257'(e.cyc));
                chk("b_state_o", state_o_b, e.val);
                last_b = e.val;
            end
        end else begin
            chk("b_hold", state_o_b, idle_view(last_b));
        end
    end

    task automatic issue_a(input logic [256:0] v, input logic [256:0] exp);
        exp_t e;
        @(posedge clk); #1;
        state_i_a = v;
        start_a   = 1'b1;
        e.val = exp;
        e.cyc = cyc + 1;
        q_a.push_back(e);
    endtask

    task automatic idle_a();
        @(posedge clk); #1;
        start_a   = 1'b0;
        state_i_a = rand257();
    endtask

    task automatic issue_b(input logic [256:0] v);
        exp_t e;
        @(posedge clk); #1;
        state_i_b = v;
        start_b   = 1'b1;
        e.val = model(v, 4);
        e.cyc = cyc + 4;
        q_b.push_back(e);
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [256:0] ones, v;
        int c0;
        ones = '1;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        state_i_a = '0; state_i_b = '0;
        #1;
        chk("reset_state_o", state_o_a, '0);
        chk("reset_busy", 257'(busy_a), 257'(0));
        chk("reset_done", 257'(done_a), 257'(0));
        @(posedge clk); #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // Directed single-round vectors, issued back to back.
        issue_a('0, 257'h1);
        issue_a(257'h1, 257'h1 << 251);
        issue_a(ones, ones & ~257'h1);
        idle_a();
        repeat (2) @(posedge clk);

        for (int n = 0; n < 120; n++) begin
            v = rand257();
            issue_a(v, model(v, 1));
            if ($urandom_range(0, 3) == 0) idle_a();
        end
        idle_a();
        repeat (3) @(posedge clk);

        // Multi-round: zero state with a start pulse while busy that must be ignored.
        @(posedge clk); #1;
        c0 = cyc;
        state_i_b = '0;
        start_b   = 1'b1;
        begin
            exp_t e;
            e.val = model('0, 4);
            e.cyc = c0 + 4;
            q_b.push_back(e);
        end
        @(posedge clk); #1;
        start_b = 1'b0;
        @(negedge clk);
        chk("b_busy_1", 257'(busy_b), 257'(1));
        @(posedge clk); #1;
        start_b   = 1'b1;
        state_i_b = rand257();
        @(negedge clk);
        chk("b_busy_2", 257'(busy_b), 257'(1));
        @(posedge clk); #1;
        start_b = 1'b0;
        @(negedge clk);
        chk("b_busy_3", 257'(busy_b), 257'(1));
        @(negedge clk);
        chk("b_busy_end", 257'(busy_b), 257'(0));
        repeat (6) @(posedge clk);

        for (int n = 0; n < 10; n++) issue_b(rand257());
        repeat (6) @(posedge clk);

        // Abort a run with an asynchronous reset in the middle of a cycle.
        @(posedge clk); #1;
        state_i_b = rand257();
        start_b   = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        @(negedge clk);
        chk("b_busy_before_abort", 257'(busy_b), 257'(1));
        @(posedge clk); #3;
        rst_b_n = 1'b0;
        #1;
        chk("b_abort_state_o", state_o_b, '0);
        chk("b_abort_busy", 257'(busy_b), 257'(0));
        chk("b_abort_done", 257'(done_b), 257'(0));
        @(posedge clk); #1;
        rst_b_n = 1'b1;
        repeat (6) @(posedge clk);

        issue_b(rand257());
        repeat (8) @(posedge clk);

        chk("a_pending", 257'(q_a.size()), 257'(0));
        chk("b_pending", 257'(q_b.size()), 257'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
